// File: rtl/wb_pkg.sv
// Shared writeback-select types: mode encoding, link offset and default-width entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

    typedef enum logic [2:0] {
        MODE_ALU  = 3'd0,
        MODE_MEM  = 3'd1,
        MODE_LUI  = 3'd2,
        MODE_LB   = 3'd3,
        MODE_LBU  = 3'd4,
        MODE_LH   = 3'd5,
        MODE_LHU  = 3'd6,
        MODE_LINK = 3'd7
    } wb_mode_t;

    // Return address for link instructions is PC plus two instruction slots.
    localparam int LINK_OFFSET = 8;

    localparam int WB_DATA_W  = 32;
    localparam int WB_RADDR_W = 5;

    // Buffered writeback entry at the default widths. Parametrised users
    // declare a same-shaped struct with their own widths.
    typedef struct packed {
        logic                  we;
        logic [WB_RADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
        logic                  misalign;
    } wb_entry_t;

endpackage

// File: rtl/wb_extract.sv
// Combinational writeback-value decode: mode/offset select, sub-word extension, link address.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
// Ports: i_mode/i_rd/i_imm/i_alu/i_mem/i_pc/i_off in; o_we/o_data/o_misalign out.
module wb_extract
    import wb_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int IMM_W   = 16,
    parameter  int RADDR_W = 5,
    localparam int OFF_W   = $clog2(DATA_W/8)
) (
    input  logic [2:0]         i_mode,
    input  logic [RADDR_W-1:0] i_rd,
    input  logic [IMM_W-1:0]   i_imm,
    input  logic [DATA_W-1:0]  i_alu,
    input  logic [DATA_W-1:0]  i_mem,
    input  logic [DATA_W-1:0]  i_pc,
    input  logic [OFF_W-1:0]   i_off,
    output logic               o_we,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_misalign
);

    wb_mode_t   w_mode;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_mis;

    assign w_mode = wb_mode_t'(i_mode);

    // Little-endian lanes: shifting right by 8*off puts the addressed lane at bit 0.
    assign w_byte = 8'(i_mem >> {i_off, 3'b000});
    assign w_half = 16'(i_mem >> {i_off, 3'b000});

    assign w_mis = ((w_mode == MODE_LH) || (w_mode == MODE_LHU)) && i_off[0];

    always_comb begin
        o_data = i_alu;
        case (w_mode)
            MODE_ALU:  o_data = i_alu;
            MODE_MEM:  o_data = i_mem;
            MODE_LUI:  o_data = {i_imm, {(DATA_W-IMM_W){1'b0}}};
            MODE_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            MODE_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
            MODE_LH:   o_data = w_mis ? '0 : {{(DATA_W-16){w_half[15]}}, w_half};
            MODE_LHU:  o_data = w_mis ? '0 : {{(DATA_W-16){1'b0}}, w_half};
            MODE_LINK: o_data = i_pc + DATA_W'(LINK_OFFSET);
            default:   o_data = i_alu;
        endcase
    end

    // x0 writes are suppressed but the value is still presented downstream.
    assign o_we       = (i_rd != '0) && !w_mis;
    assign o_misalign = w_mis;

endmodule

// File: rtl/wb_select_stage.sv
// Registered writeback select into a 2-entry skid FIFO between MEM/WB and the register file.
// Latency: 1 cycle from accepted input to out_valid.
// Backpressure: out_ready low holds the head; in_ready (registered) drops when both entries are full.
// Ports: clk, reset_n; upstream in_valid/in_ready + in_mode/rd/imm/alu/mem/pc/off;
//        downstream out_valid/out_ready + out_we/rd/data/misalign.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int IMM_W   = 16,
    parameter  int RADDR_W = 5,
    localparam int OFF_W   = $clog2(DATA_W/8)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_mode,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [DATA_W-1:0]  in_mem,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic [OFF_W-1:0]   in_off,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_we,
    output logic [RADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_misalign
);

    typedef struct packed {
        logic               we;
        logic [RADDR_W-1:0] rd;
        logic [DATA_W-1:0]  data;
        logic               misalign;
    } entry_t;

    entry_t     r_buf [2];
    logic       r_head;
    logic [1:0] r_count;
    logic       r_in_ready;

    entry_t     w_new;
    logic       w_push;
    logic       w_pop;
    logic       w_tail;
    logic [1:0] w_count_nxt;

    wb_extract #(
        .DATA_W  (DATA_W),
        .IMM_W   (IMM_W),
        .RADDR_W (RADDR_W)
    ) u_extract (
        .i_mode     (in_mode),
        .i_rd       (in_rd),
        .i_imm      (in_imm),
        .i_alu      (in_alu),
        .i_mem      (in_mem),
        .i_pc       (in_pc),
        .i_off      (in_off),
        .o_we       (w_new.we),
        .o_data     (w_new.data),
        .o_misalign (w_new.misalign)
    );

    assign w_new.rd = in_rd;

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = (r_count != 2'd0) && out_ready;
    // Tail slot: same as head when empty, the other slot when one entry is held.
    assign w_tail = r_head ^ r_count[0];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_buf[w_tail] <= w_new;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count    <= w_count_nxt;
            // Registered so upstream never sees a combinational path from out_ready.
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = (r_count != 2'd0);
    assign out_we       = out_valid && r_buf[r_head].we;
    assign out_rd       = r_buf[r_head].rd;
    assign out_data     = r_buf[r_head].data;
    assign out_misalign = r_buf[r_head].misalign;

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: decode table, backpressure, mid-operation reset.
// Latency: expects results one cycle after acceptance.
// Backpressure: scoreboard pops only on out_valid & out_ready.
module tb_wb_select_stage;
    import wb_pkg::*;

    localparam int DW = 32;
    localparam int IW = 16;
    localparam int RW = 5;
    localparam int OW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_mode;
    logic [RW-1:0] in_rd;
    logic [IW-1:0] in_imm;
    logic [DW-1:0] in_alu;
    logic [DW-1:0] in_mem;
    logic [DW-1:0] in_pc;
    logic [OW-1:0] in_off;
    logic          out_valid;
    logic          out_ready;
    logic          out_we;
    logic [RW-1:0] out_rd;
    logic [DW-1:0] out_data;
    logic          out_misalign;

    always #5 clk = ~clk;

    wb_select_stage #(.DATA_W(DW), .IMM_W(IW), .RADDR_W(RW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_rd        (in_rd),
        .in_imm       (in_imm),
        .in_alu       (in_alu),
        .in_mem       (in_mem),
        .in_pc        (in_pc),
        .in_off       (in_off),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_we       (out_we),
        .out_rd       (out_rd),
        .out_data     (out_data),
        .out_misalign (out_misalign)
    );

    typedef struct packed {
        logic          we;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        logic          mis;
    } exp_t;

    typedef struct packed {
        wb_mode_t      mode;
        logic [RW-1:0] rd;
        logic [IW-1:0] imm;
        logic [DW-1:0] alu;
        logic [DW-1:0] mem;
        logic [DW-1:0] pc;
        logic [OW-1:0] off;
        logic          exp_we;
        logic [DW-1:0] exp_data;
        logic          exp_mis;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    exp_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input wb_mode_t m, input logic [RW-1:0] rd,
                                input logic [IW-1:0] imm, input logic [DW-1:0] alu,
                                input logic [DW-1:0] mem, input logic [DW-1:0] pc,
                                input logic [OW-1:0] off, input logic we,
                                input logic [DW-1:0] d, input logic mis);
        vec_t v;
        v.mode = m; v.rd = rd; v.imm = imm; v.alu = alu; v.mem = mem; v.pc = pc;
        v.off = off; v.exp_we = we; v.exp_data = d; v.exp_mis = mis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Scoreboard consumer: every handshake pops and compares the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && reset_n === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (out_ready === 1'b1) begin
                    exp_t act;
                    exp_t req;
                    act = '{we: out_we, rd: out_rd, data: out_data, mis: out_misalign};
                    n_tests++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output: got rd=%0d data=%h, required no output",
                                 out_rd, out_data);
                    end else begin
                        req = sb_q.pop_front();
                        if (act !== req) begin
                            n_fail++;
                            $display("FAIL sb_entry: got we=%b rd=%0d data=%h mis=%b required we=%b rd=%0d data=%h mis=%b",
                                     act.we, act.rd, act.data, act.mis, req.we, req.rd, req.data, req.mis);
                        end
                    end
                end
            end else begin
                n_tests++;
                if (out_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_we: got %b required 0", out_we);
                end
            end
        end
    end

    task automatic push_entry(input vec_t v);
        int waited;
        waited   = 0;
        in_mode  = v.mode;
        in_rd    = v.rd;
        in_imm   = v.imm;
        in_alu   = v.alu;
        in_mem   = v.mem;
        in_pc    = v.pc;
        in_off   = v.off;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: got in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back('{we: v.exp_we, rd: v.rd, data: v.exp_data, mis: v.exp_mis});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int c;
        c = 0;
        while (sb_q.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk(nm, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t a, b, c, d, e;
        int   c0;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mode = '0; in_rd = '0; in_imm = '0; in_alu = '0; in_mem = '0; in_pc = '0; in_off = '0;

        vecs[0]  = mk(MODE_LUI,  5'd8,  16'hFFFF, 32'h0,        32'h0,        32'h0,        2'd0, 1'b1, 32'hFFFF0000, 1'b0);
        vecs[1]  = mk(MODE_MEM,  5'd3,  16'h0,    32'h0,        32'h55555555, 32'h0,        2'd0, 1'b1, 32'h55555555, 1'b0);
        vecs[2]  = mk(MODE_LUI,  5'd3,  16'h0001, 32'h0,        32'h55555555, 32'h0,        2'd0, 1'b1, 32'h00010000, 1'b0);
        vecs[3]  = mk(MODE_LB,   5'd4,  16'h0,    32'h0,        32'h12803456, 32'h0,        2'd2, 1'b1, 32'hFFFFFF80, 1'b0);
        vecs[4]  = mk(MODE_LBU,  5'd4,  16'h0,    32'h0,        32'h12803456, 32'h0,        2'd2, 1'b1, 32'h00000080, 1'b0);
        vecs[5]  = mk(MODE_LH,   5'd5,  16'h0,    32'h0,        32'h12803456, 32'h0,        2'd2, 1'b1, 32'h00001280, 1'b0);
        vecs[6]  = mk(MODE_LH,   5'd5,  16'h0,    32'h0,        32'h12803456, 32'h0,        2'd1, 1'b0, 32'h00000000, 1'b1);
        vecs[7]  = mk(MODE_ALU,  5'd0,  16'h0,    32'hDEADBEEF, 32'h0,        32'h0,        2'd0, 1'b0, 32'hDEADBEEF, 1'b0);
        vecs[8]  = mk(MODE_LINK, 5'd1,  16'h0,    32'h0,        32'h0,        32'hFFFFFFFC, 2'd0, 1'b1, 32'h00000004, 1'b0);
        vecs[9]  = mk(MODE_LB,   5'd6,  16'h0,    32'h0,        32'h12803456, 32'h0,        2'd0, 1'b1, 32'h00000056, 1'b0);
        vecs[10] = mk(MODE_LB,   5'd6,  16'h0,    32'h0,        32'h12803456, 32'h0,        2'd3, 1'b1, 32'h00000012, 1'b0);
        vecs[11] = mk(MODE_LHU,  5'd7,  16'h0,    32'h0,        32'h80010000, 32'h0,        2'd2, 1'b1, 32'h00008001, 1'b0);
        vecs[12] = mk(MODE_LH,   5'd7,  16'h0,    32'h0,        32'h80010000, 32'h0,        2'd2, 1'b1, 32'hFFFF8001, 1'b0);
        vecs[13] = mk(MODE_LHU,  5'd9,  16'h0,    32'h0,        32'h80010000, 32'h0,        2'd3, 1'b0, 32'h00000000, 1'b1);
        vecs[14] = mk(MODE_LINK, 5'd31, 16'h0,    32'h0,        32'h0,        32'h00001000, 2'd0, 1'b1, 32'h00001008, 1'b0);
        vecs[15] = mk(MODE_ALU,  5'd31, 16'h0,    32'h0,        32'hFFFFFFFF, 32'h0,        2'd0, 1'b1, 32'h00000000, 1'b0);
        vecs[16] = mk(MODE_LH,   5'd2,  16'h0,    32'h0,        32'h0000F00D, 32'h0,        2'd0, 1'b1, 32'hFFFFF00D, 1'b0);

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid),    64'd0);
        chk("rst_in_ready",  64'(in_ready),     64'd1);
        chk("rst_out_we",    64'(out_we),       64'd0);
        chk("rst_out_rd",    64'(out_rd),       64'd0);
        chk("rst_out_data",  64'(out_data),     64'd0);
        chk("rst_out_mis",   64'(out_misalign), 64'd0);
        #5 reset_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Decode table at full throughput: one acceptance per cycle.
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < NV; i++) push_entry(vecs[i]);
        chk("throughput_cycles", 64'(cyc - c0), 64'(NV));
        wait_drain("table_drain");

        // Backpressure: A,B fill the buffer, C waits upstream, then A,B,C drain back to back.
        a = mk(MODE_ALU, 5'd10, 16'h0, 32'hAAAA0001, 32'h0, 32'h0, 2'd0, 1'b1, 32'hAAAA0001, 1'b0);
        b = mk(MODE_ALU, 5'd11, 16'h0, 32'hBBBB0002, 32'h0, 32'h0, 2'd0, 1'b1, 32'hBBBB0002, 1'b0);
        c = mk(MODE_MEM, 5'd12, 16'h0, 32'h0, 32'hCCCC0003, 32'h0, 2'd0, 1'b1, 32'hCCCC0003, 1'b0);
        out_ready = 1'b0;
        push_entry(a);
        push_entry(b);
        chk("bp_full_in_ready", 64'(in_ready), 64'd0);
        fork
            push_entry(c);
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("bp_hold_in_ready", 64'(in_ready),  64'd0);
                chk("bp_hold_valid",    64'(out_valid), 64'd1);
                chk("bp_hold_data",     64'(out_data),  64'(a.exp_data));
                chk("bp_hold_rd",       64'(out_rd),    64'(a.rd));
                out_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_no_gap", 64'(out_valid), 64'd1);
                end
            end
        join
        wait_drain("bp_drain");

        // Asynchronous reset between edges drops both buffered entries.
        d = mk(MODE_ALU, 5'd13, 16'h0, 32'hD0D0D0D0, 32'h0, 32'h0, 2'd0, 1'b1, 32'hD0D0D0D0, 1'b0);
        e = mk(MODE_ALU, 5'd14, 16'h0, 32'hE0E0E0E0, 32'h0, 32'h0, 2'd0, 1'b1, 32'hE0E0E0E0, 1'b0);
        out_ready = 1'b0;
        push_entry(d);
        push_entry(e);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid",    64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready),  64'd1);
        chk("mid_rst_we",       64'(out_we),    64'd0);
        chk("mid_rst_data",     64'(out_data),  64'd0);
        sb_q.delete();
        #3 reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Registered writeback-select stage between the MEM/WB pipeline boundary and the register file.
- Parametrised successor to the combinational LUI/memory writeback mux.
- Selects the writeback value from ALU result, memory word, LUI immediate, sub-word loads (sign/zero-extended) or link address.
- Buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides, so the register-file port can stall without losing data.

Parameters:
- DATA_W, 32: datapath width. Must be a power of two, ≥32.
- IMM_W, 16: immediate width. IMM_W < DATA_W.
- RADDR_W, 5: register address width.
- OFF_W, $clog2(DATA_W/8): byte-offset width. Derived; do not override.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_mode  in  3  writeback mode (see package)
- in_rd  in  RADDR_W  destination register
- in_imm  in  IMM_W  immediate
- in_alu  in  DATA_W  ALU result
- in_mem  in  DATA_W  memory read word
- in_pc  in  DATA_W  instruction PC
- in_off  in  OFF_W  byte offset of the load address
- out_valid  out  1  result valid
- out_ready  in  1  register file accepts result
- out_we  out  1  register write enable
- out_rd  out  RADDR_W  destination register
- out_data  out  DATA_W  writeback value
- out_misalign  out  1  misaligned halfword load flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Reset values: on reset_n low, asynchronously clear both buffer entries and count to 0. Outputs go to out_valid=0, out_we=0, out_rd=0, out_data=0, out_misalign=0, in_ready=1.
- Mode decode (combinational, at input):
  - ALU → in_alu.
  - MEM → in_mem.
  - LUI → {in_imm, (DATA_W-IMM_W)'b0}.
  - LB → sign-extend byte at in_off. Little-endian lanes: lane k = bits[8k+7:8k].
  - LBU → zero-extend that byte.
  - LH → sign-extend halfword at in_off.
  - LHU → zero-extend halfword at in_off.
  - LINK → in_pc + 8, modulo 2^DATA_W (wraps).
- Misaligned halfword: LH/LHU with in_off[0]=1 sets misalign=1, we=0, data=0.
- Write enable: we = 1 unless rd==0 or misaligned. For rd==0 the data is still computed and presented.
- Undefined mode codes: decode as ALU.
- Latency: decoded result is captured on an accepted input (in_valid & in_ready). It appears on the outputs the next cycle. No combinational path from in_* to out_*.
- Buffer: 2-entry FIFO of {we, rd, data, misalign}, plus a count of 0–2.
  - in_ready = (count < 2), registered.
  - out_valid = (count > 0).
  - Head entry drives out_*. Entries retire in order.
- Simultaneous push and pop: count unchanged.
  - With count=1, the new entry becomes head the next cycle.
  - With count=2, push is impossible because in_ready=0.
- Output hold: while out_valid & !out_ready, out_* are held stable. When out_valid=0, out_* hold their last values (don't care), but out_we=0 is forced.
- Full throughput: with out_ready held at 1, one entry is accepted per cycle.
- Reset mid-operation: all buffered entries are dropped. No partial write is emitted.

Decomposition:
- Shared package wb_pkg: wb_mode_t enum with MODE_ALU=0, MODE_MEM=1, MODE_LUI=2, MODE_LB=3, MODE_LBU=4, MODE_LH=5, MODE_LHU=6, MODE_LINK=7; the LINK_OFFSET=8 constant; and the wb_entry_t struct.
- Sub-module wb_extract: purely combinational mode/offset decode. Feeds the buffer logic in the top module.

Test Plan:
- LUI: in_imm=16'hFFFF, in_rd=8, mode LUI, out_ready=1 → next cycle out_data=32'hFFFF0000, out_we=1, out_rd=8.
- MEM vs LUI: in_mem=32'h55555555, mode MEM → 32'h55555555. Same data with mode LUI and imm=16'h0001 → 32'h00010000.
- Sub-word loads, in_mem=32'h12803456:
  - LB off=2 → 32'hFFFFFF80.
  - LBU off=2 → 32'h00000080.
  - LH off=2 → 32'h00001280.
  - LH off=1 → out_misalign=1, out_we=0.
- rd zero and link:
  - rd=0, mode ALU, in_alu=32'hDEADBEEF → out_data=32'hDEADBEEF, out_we=0.
  - LINK with in_pc=32'hFFFFFFFC → out_data=32'h00000004.
- Backpressure: out_ready=0, push A,B,C on consecutive cycles → in_ready=0 after B; C held upstream. Raise out_ready → outputs A,B,C in order, one per cycle, with no gaps.
- Reset mid-operation: 2 entries buffered, pulse reset_n low asynchronously between clock edges → out_valid=0 and in_ready=1 immediately. No entry is emitted after release.
